// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO between the command interpreter's response
// stream and the UART transmitter. Buffered bytes are launched one at a
// time with a single-cycle transmit strobe, only while the UART is idle.
//
// Handshake semantics:
//   wr_valid_i is a fire-and-forget strobe with no ready. The byte is
//   accepted when full_o (pre-edge) is low and flush_i is low. Otherwise it
//   is dropped, and overflow_o is set only when the drop was caused by full_o.
//   transmit_o is a one-cycle command to the UART with no ready. The UART
//   acknowledges by raising tx_busy_i. If tx_busy_i stays low for
//   START_TIMEOUT cycles, the byte is treated as sent.
module uart_tx_buffer #(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_valid_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     flush_i,
    input  logic                     tx_busy_i,
    output logic                     transmit_o,
    output logic [7:0]               tx_byte_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LAUNCH_WAIT = 2'd1,
        ST_BUSY        = 2'd2
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          transmit_q;
    logic [7:0]    tx_byte_q;
    logic [TW-1:0] wait_cnt_q;
    state_t        state_q;
    state_t        state_d;
    logic          launch;
    logic          push;
    logic          pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign transmit_o = transmit_q;
    assign tx_byte_o  = tx_byte_q;

    // A same-cycle pop never frees room for a push: full_o is the pre-edge value.
    assign push = wr_valid_i && !full_o && !flush_i;
    assign pop  = launch;

    // Launch controller: next state and the launch (pop) decision.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_o && !tx_busy_i && !flush_i) begin
                    launch  = 1'b1;
                    state_d = ST_LAUNCH_WAIT;
                end
            end
            ST_LAUNCH_WAIT: begin
                if (tx_busy_i) begin
                    state_d = ST_BUSY;
                end else if (wait_cnt_q == TW'(START_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; flush does not touch it so a launched byte completes.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts cycles spent waiting for the UART to acknowledge a launch.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || state_q != ST_LAUNCH_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
        end
    end

    // FIFO pointers, occupancy and sticky overflow; flush overrides push and pop.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AW+1)'(1);
            end
            if (wr_valid_i && full_o) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Launch outputs: one-cycle strobe, byte held until the next launch.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            transmit_q <= launch;
            if (launch) begin
                tx_byte_q <= mem[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: UART behaviour model, launch monitor with an
// expected-byte queue, and one task per scenario.
module tb_uart_tx_buffer;

    localparam int DEPTH         = 16;
    localparam int START_TIMEOUT = 4;
    localparam int CW            = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [7:0]    wr_data;
    logic          flush;
    logic          tx_busy;
    logic          transmit;
    logic [7:0]    tx_byte;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         tx_cyc_q[$];

    // UART model control: 0 = busy for busy_len cycles after each strobe,
    // 1 = tied low, 2 = held high
    int uart_mode   = 0;
    int busy_len    = 20;
    int busy_left   = 0;
    bit resp_busy   = 0;
    int fall_cycle  = -1000;
    int max_count   = 0;
    bit mon_en      = 0;

    uart_tx_buffer #(
        .DEPTH(DEPTH),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .wr_valid_i (wr_valid),
        .wr_data_i  (wr_data),
        .flush_i    (flush),
        .tx_busy_i  (tx_busy),
        .transmit_o (transmit),
        .tx_byte_o  (tx_byte),
        .empty_o    (empty),
        .full_o     (full),
        .count_o    (count),
        .overflow_o (overflow)
    );

    // clock and cycle counter
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // UART model: drives tx_busy 2 time units after each rising edge
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (uart_mode)
                0: begin
                    if (busy_left > 0) begin
                        tx_busy   = 1'b1;
                        resp_busy = 1'b1;
                        busy_left--;
                    end else begin
                        if (tx_busy === 1'b1 && resp_busy) fall_cycle = cyc;
                        tx_busy   = 1'b0;
                        resp_busy = 1'b0;
                    end
                end
                1: begin
                    tx_busy   = 1'b0;
                    resp_busy = 1'b0;
                    busy_left = 0;
                end
                default: begin
                    tx_busy   = 1'b1;
                    resp_busy = 1'b0;
                    busy_left = 0;
                end
            endcase
        end
    end

    // scoreboard monitor: every strobe must carry the oldest accepted byte
    initial begin
        logic       prev_tx;
        logic       prev_busy;
        logic       prev_rst;
        logic [7:0] prev_byte;
        logic [7:0] exp_b;
        prev_tx   = 1'b0;
        prev_busy = 1'b0;
        prev_rst  = 1'b0;
        prev_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (transmit === 1'b1) begin
                    tx_cyc_q.push_back(cyc);
                    if (uart_mode == 0) busy_left = busy_len;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_transmit: got byte %02h, expected no launch (cycle %0d)", tx_byte, cyc);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (tx_byte !== exp_b) begin
                            errors++;
                            $display("FAIL tx_byte: got %02h, expected %02h (cycle %0d)", tx_byte, exp_b, cyc);
                        end
                    end
                    checks++;
                    if (prev_tx !== 1'b0) begin
                        errors++;
                        $display("FAIL strobe_width: transmit high in cycles %0d and %0d, expected one cycle", cyc - 1, cyc);
                    end
                    checks++;
                    if (prev_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL launch_while_busy: tx_busy before launch was %b, expected 0", prev_busy);
                    end
                    checks++;
                    if (cyc - fall_cycle < 2) begin
                        errors++;
                        $display("FAIL launch_gap: launch %0d cycles after busy fell, expected >= 2", cyc - fall_cycle);
                    end
                end else if (prev_rst === 1'b1) begin
                    checks++;
                    if (tx_byte !== prev_byte) begin
                        errors++;
                        $display("FAIL tx_byte_hold: got %02h, expected held %02h (cycle %0d)", tx_byte, prev_byte, cyc);
                    end
                end
                if (int'(count) > max_count) max_count = int'(count);
            end
            prev_tx   = transmit;
            prev_busy = tx_busy;
            prev_byte = tx_byte;
            prev_rst  = rst_n;
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input bit accept);
        wr_valid = 1'b1;
        wr_data  = d;
        if (accept) exp_q.push_back(d);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int k;
        int quiet;
        k = 0;
        quiet = 0;
        while (quiet < 8 && k < max_cyc) begin
            @(negedge clk);
            k++;
            if (exp_q.size() == 0 && tx_busy === 1'b0 && count === '0) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 8) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes still expected, count %0d after %0d cycles", exp_q.size(), count, k);
        end
        step();
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (count !== '0) begin errors++; $display("FAIL %s_count: got %0d, expected 0", tag, count); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL %s_empty: got %b, expected 1", tag, empty); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL %s_full: got %b, expected 0", tag, full); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL %s_overflow: got %b, expected 0", tag, overflow); end
        checks++;
        if (transmit !== 1'b0) begin errors++; $display("FAIL %s_transmit: got %b, expected 0", tag, transmit); end
        checks++;
        if (tx_byte !== 8'h00) begin errors++; $display("FAIL %s_tx_byte: got %02h, expected 00", tag, tx_byte); end
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_single();
        int n;
        uart_mode = 0;
        busy_len  = 20;
        tx_cyc_q.delete();
        step();
        n = cyc;
        wr(8'hA5, 1);
        @(negedge clk);
        checks++;
        if (count !== CW'(1)) begin errors++; $display("FAIL single_count_n1: got %0d, expected 1", count); end
        wait_drain(200);
        checks++;
        if (tx_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL single_pulses: got %0d, expected 1", tx_cyc_q.size());
        end else begin
            checks++;
            if (tx_cyc_q[0] != n + 2) begin errors++; $display("FAIL single_latency: got cycle %0d, expected %0d", tx_cyc_q[0], n + 2); end
        end
        checks++;
        if (count !== '0 || empty !== 1'b1) begin errors++; $display("FAIL single_drained: got count %0d empty %b, expected 0/1", count, empty); end
    endtask

    task automatic test_burst();
        tx_cyc_q.delete();
        busy_len  = 20;
        max_count = 0;
        step();
        for (int i = 1; i <= 5; i++) wr(8'(i), 1);
        wait_drain(400);
        checks++;
        if (tx_cyc_q.size() != 5) begin errors++; $display("FAIL burst_pulses: got %0d, expected 5", tx_cyc_q.size()); end
        checks++;
        if (max_count != 4) begin errors++; $display("FAIL burst_peak: got %0d, expected 4", max_count); end
    endtask

    task automatic test_overflow();
        int base;
        uart_mode = 2;
        repeat (3) step();
        base = tx_cyc_q.size();
        for (int i = 0; i < DEPTH; i++) wr(8'h40 + 8'(i), 1);
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_full: got full %b count %0d, expected 1/%0d", full, count, DEPTH); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, expected 0", overflow); end
        step();
        wr(8'hEE, 0);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || count !== CW'(DEPTH)) begin errors++; $display("FAIL ovf_drop: got overflow %b count %0d, expected 1/%0d", overflow, count, DEPTH); end
        repeat (5) step();
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
        step();
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h77;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL flush_state: got count %0d empty %b full %b, expected 0/1/0", count, empty, full); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b, expected 0", overflow); end
        step();
        uart_mode = 0;
        repeat (30) step();
        checks++;
        if (tx_cyc_q.size() != base) begin errors++; $display("FAIL flush_no_launch: got %0d launches, expected 0", tx_cyc_q.size() - base); end
    endtask

    task automatic test_simul();
        logic [7:0] a;
        logic [7:0] b;
        int base;
        a = 8'($urandom);
        b = 8'($urandom);
        busy_len  = 20;
        uart_mode = 2;
        repeat (3) step();
        base = tx_cyc_q.size();
        wr(a, 1);
        repeat (2) step();
        uart_mode = 0;
        wr(b, 1);
        @(negedge clk);
        checks++;
        if (count !== CW'(1)) begin errors++; $display("FAIL simul_count: got %0d, expected 1", count); end
        checks++;
        if (transmit !== 1'b1) begin errors++; $display("FAIL simul_launch: got transmit %b, expected 1", transmit); end
        wait_drain(200);
        checks++;
        if (tx_cyc_q.size() - base != 2) begin errors++; $display("FAIL simul_pulses: got %0d, expected 2", tx_cyc_q.size() - base); end
    endtask

    task automatic test_timeout();
        int n;
        int n2;
        uart_mode = 1;
        repeat (2) step();
        tx_cyc_q.delete();
        n = cyc;
        wr(8'h3C, 1);
        wr(8'h5A, 1);
        wait_drain(100);
        checks++;
        if (tx_cyc_q.size() != 2) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d, expected 2", tx_cyc_q.size());
        end else begin
            checks++;
            if (tx_cyc_q[0] != n + 2) begin errors++; $display("FAIL timeout_first: got cycle %0d, expected %0d", tx_cyc_q[0], n + 2); end
            checks++;
            if (tx_cyc_q[1] != n + 3 + START_TIMEOUT) begin errors++; $display("FAIL timeout_release: got cycle %0d, expected %0d", tx_cyc_q[1], n + 3 + START_TIMEOUT); end
        end
        n2 = cyc;
        wr(8'h96, 1);
        wait_drain(100);
        checks++;
        if (tx_cyc_q.size() != 3) begin
            errors++;
            $display("FAIL timeout_third_pulses: got %0d, expected 3", tx_cyc_q.size());
        end else begin
            checks++;
            if (tx_cyc_q[2] != n2 + 2) begin errors++; $display("FAIL timeout_third: got cycle %0d, expected %0d", tx_cyc_q[2], n2 + 2); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        uart_mode = 0;
        busy_len  = 20;
        step();
        for (int i = 0; i < 4; i++) wr(8'($urandom), 1);
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (count !== CW'(3) || tx_busy !== 1'b1) begin errors++; $display("FAIL mid_setup: got count %0d busy %b, expected 3/1", count, tx_busy); end
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        base = tx_cyc_q.size();
        @(negedge clk);
        check_reset_values("mid_reset");
        repeat (40) step();
        checks++;
        if (tx_cyc_q.size() != base) begin errors++; $display("FAIL mid_no_launch: got %0d launches, expected 0", tx_cyc_q.size() - base); end
        checks++;
        if (count !== '0) begin errors++; $display("FAIL mid_count: got %0d, expected 0", count); end
    endtask

    task automatic test_random();
        int nw;
        int base;
        for (int r = 0; r < 4; r++) begin
            busy_len  = $urandom_range(1, 12);
            uart_mode = (r == 2) ? 1 : 0;
            nw        = $urandom_range(8, DEPTH);
            base      = tx_cyc_q.size();
            step();
            for (int i = 0; i < nw; i++) begin
                wr(8'($urandom), 1);
                repeat ($urandom_range(0, 3)) step();
            end
            wait_drain(1500);
            checks++;
            if (tx_cyc_q.size() - base != nw) begin errors++; $display("FAIL random_pulses: round %0d got %0d, expected %0d", r, tx_cyc_q.size() - base, nw); end
            checks++;
            if (overflow !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL random_final: round %0d got overflow %b empty %b, expected 0/1", r, overflow, empty); end
        end
    endtask

    // main sequence and final report
    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        flush    = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_simul();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
